// File: rtl/hyper_txn_sched.sv
// hyper_txn_sched
// Round-robin transaction scheduler in front of the uDMA HyperBus channel
// configuration port. One transfer at a time is programmed with four
// configuration writes (L2 address, size, external address, command). The
// scheduler then waits for the channel EOT and returns a one-cycle completion
// pulse, tagged with direction, to the owning requester.
//
// Optional feature: define HYPER_SCHED_TIMEOUT_EN to add a BUSY-phase timeout
// counter. On expiry an abort command is written to the channel and the
// transfer completes with done_err_o set. Without the macro, BUSY waits for
// EOT indefinitely, timeout_i is ignored and done_err_o is constant 0.
//
// All outputs are registered. Reset is synchronous and active-low.

module hyper_txn_sched #(
  parameter int NB_REQ         = 2,
  parameter int L2_AWIDTH_NOAL = 19,
  parameter int TRANS_SIZE     = 20,
  parameter int EXT_AWIDTH     = 32,
  parameter int TO_WIDTH       = 16
) (
  input  logic                               sys_clk_i,
  input  logic                               rstn_i,

  input  logic [NB_REQ-1:0]                  req_valid_i,
  output logic [NB_REQ-1:0]                  req_ready_o,
  input  logic [NB_REQ-1:0]                  req_rwn_i,
  input  logic [NB_REQ*L2_AWIDTH_NOAL-1:0]   req_l2addr_i,
  input  logic [NB_REQ*EXT_AWIDTH-1:0]       req_extaddr_i,
  input  logic [NB_REQ*TRANS_SIZE-1:0]       req_size_i,

  output logic [NB_REQ-1:0]                  done_o,
  output logic                               done_rwn_o,
  output logic                               done_err_o,

  output logic                               cfg_valid_o,
  output logic [4:0]                         cfg_addr_o,
  output logic [31:0]                        cfg_data_o,
  output logic                               cfg_rwn_o,
  input  logic                               cfg_ready_i,

  input  logic                               eot_i,
  output logic                               busy_o,
  output logic                               busy_rwn_o,

  input  logic [TO_WIDTH-1:0]                timeout_i
);

  localparam int IDX_W = $clog2(NB_REQ);

  // Channel configuration word indices and command encodings.
  localparam logic [4:0]  CFG_L2   = 5'd0;
  localparam logic [4:0]  CFG_SIZE = 5'd1;
  localparam logic [4:0]  CFG_EXT  = 5'd2;
  localparam logic [4:0]  CFG_CMD  = 5'd3;
  localparam logic [31:0] CMD_ABORT = 32'h0000_0004;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GRANT,
    S_W_L2,
    S_W_SIZE,
    S_W_EXT,
    S_W_CMD,
    S_BUSY,
`ifdef HYPER_SCHED_TIMEOUT_EN
    S_ABORT,
`endif
    S_DONE
  } state_e;

  state_e                   state_q;
  logic [IDX_W-1:0]         last_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     rwn_q;
  logic [TRANS_SIZE-1:0]    size_q;
  logic [EXT_AWIDTH-1:0]    ext_q;

  // Round-robin winner search.
  logic                     win_found;
  logic [IDX_W-1:0]         win_idx;
  logic [IDX_W-1:0]         cand_idx;
  int                       cand_pos;

  // Fields of the granted requester, picked from the flattened buses.
  logic [L2_AWIDTH_NOAL-1:0] sel_l2;
  logic [TRANS_SIZE-1:0]     sel_size;
  logic [EXT_AWIDTH-1:0]     sel_ext;
  logic                      sel_rwn;

  assign sel_l2   = req_l2addr_i[int'(idx_q)*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
  assign sel_size = req_size_i[int'(idx_q)*TRANS_SIZE +: TRANS_SIZE];
  assign sel_ext  = req_extaddr_i[int'(idx_q)*EXT_AWIDTH +: EXT_AWIDTH];
  assign sel_rwn  = req_rwn_i[idx_q];

  // The configuration port is only ever written.
  assign cfg_rwn_o = 1'b0;

`ifdef HYPER_SCHED_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_cnt_q;
  logic [TO_WIDTH-1:0] to_cnt_nxt;
  logic                done_err_q;
  logic                to_expired;

  assign to_cnt_nxt = to_cnt_q + 1'b1;
  // Expiry is judged on the incremented count so that a limit of N allows
  // exactly N BUSY cycles before the abort.
  assign to_expired = (timeout_i != '0) && (to_cnt_nxt == timeout_i);
  assign done_err_o = done_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign done_err_o     = 1'b0;
`endif

  // Pick the first valid requester strictly after the last one served.
  // NOTE: always_comb uses blocking assignments and gives every variable a
  // default first, so the loop search is order-dependent and no latch forms.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_pos  = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NB_REQ; i++) begin
      cand_pos = int'(last_q) + i;
      if (cand_pos >= NB_REQ) cand_pos = cand_pos - NB_REQ;
      cand_idx = IDX_W'(cand_pos);
      if (!win_found && req_valid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Scheduler FSM with registered outputs driven on each transition.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge value of every other one.
  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      last_q      <= IDX_W'(NB_REQ - 1);
      idx_q       <= '0;
      rwn_q       <= 1'b0;
      size_q      <= '0;
      ext_q       <= '0;
      req_ready_o <= '0;
      done_o      <= '0;
      done_rwn_o  <= 1'b0;
      cfg_valid_o <= 1'b0;
      cfg_addr_o  <= '0;
      cfg_data_o  <= '0;
      busy_o      <= 1'b0;
      busy_rwn_o  <= 1'b0;
`ifdef HYPER_SCHED_TIMEOUT_EN
      to_cnt_q    <= '0;
      done_err_q  <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; they are raised only on the entry edge.
      req_ready_o <= '0;
      done_o      <= '0;
      done_rwn_o  <= 1'b0;
`ifdef HYPER_SCHED_TIMEOUT_EN
      done_err_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q              <= S_GRANT;
            idx_q                <= win_idx;
            req_ready_o[win_idx] <= 1'b1;
          end
        end

        S_GRANT: begin
          last_q <= idx_q;
          rwn_q  <= sel_rwn;
          size_q <= sel_size;
          ext_q  <= sel_ext;
          if (sel_size == '0) begin
            // Nothing to move: complete immediately without touching the channel.
            state_q       <= S_DONE;
            done_o[idx_q] <= 1'b1;
            done_rwn_o    <= sel_rwn;
          end else begin
            state_q     <= S_W_L2;
            cfg_valid_o <= 1'b1;
            cfg_addr_o  <= CFG_L2;
            cfg_data_o  <= 32'(sel_l2);
          end
        end

        S_W_L2: begin
          if (cfg_ready_i) begin
            state_q    <= S_W_SIZE;
            cfg_addr_o <= CFG_SIZE;
            cfg_data_o <= 32'(size_q);
          end
        end

        S_W_SIZE: begin
          if (cfg_ready_i) begin
            state_q    <= S_W_EXT;
            cfg_addr_o <= CFG_EXT;
            cfg_data_o <= 32'(ext_q);
          end
        end

        S_W_EXT: begin
          if (cfg_ready_i) begin
            state_q    <= S_W_CMD;
            cfg_addr_o <= CFG_CMD;
            cfg_data_o <= {30'd0, 1'b1, rwn_q};
          end
        end

        S_W_CMD: begin
          if (cfg_ready_i) begin
            state_q     <= S_BUSY;
            cfg_valid_o <= 1'b0;
            cfg_addr_o  <= '0;
            cfg_data_o  <= '0;
            busy_o      <= 1'b1;
            busy_rwn_o  <= rwn_q;
`ifdef HYPER_SCHED_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
          end
        end

        S_BUSY: begin
          // EOT is checked first so it beats a timeout expiring on the same cycle.
          if (eot_i) begin
            state_q       <= S_DONE;
            busy_o        <= 1'b0;
            busy_rwn_o    <= 1'b0;
            done_o[idx_q] <= 1'b1;
            done_rwn_o    <= rwn_q;
`ifdef HYPER_SCHED_TIMEOUT_EN
          end else if (to_expired) begin
            state_q     <= S_ABORT;
            busy_o      <= 1'b0;
            busy_rwn_o  <= 1'b0;
            cfg_valid_o <= 1'b1;
            cfg_addr_o  <= CFG_CMD;
            cfg_data_o  <= CMD_ABORT;
          end else begin
            to_cnt_q <= to_cnt_nxt;
`endif
          end
        end

`ifdef HYPER_SCHED_TIMEOUT_EN
        S_ABORT: begin
          // A late EOT here is ignored; the transfer completes as an error.
          if (cfg_ready_i) begin
            state_q       <= S_DONE;
            cfg_valid_o   <= 1'b0;
            cfg_addr_o    <= '0;
            cfg_data_o    <= '0;
            done_o[idx_q] <= 1'b1;
            done_rwn_o    <= rwn_q;
            done_err_q    <= 1'b1;
          end
        end
`endif

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_txn_sched.sv
// Self-checking bench for hyper_txn_sched. Randomised requester fields and
// request masks are checked against a reference model of the scheduler's
// rules: round-robin order, the four-word programming sequence and its
// encodings, EOT/timeout completion and the zero-size shortcut.
`timescale 1ns/1ps

module tb_hyper_txn_sched;

  localparam int NB  = 2;
  localparam int IW  = $clog2(NB);
  localparam int L2W = 19;
  localparam int SZW = 20;
  localparam int EXW = 32;
  localparam int TOW = 16;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NB-1:0]      req_valid;
  logic [NB-1:0]      req_ready;
  logic [NB-1:0]      req_rwn;
  logic [NB*L2W-1:0]  req_l2addr;
  logic [NB*EXW-1:0]  req_extaddr;
  logic [NB*SZW-1:0]  req_size;
  logic [NB-1:0]      done_o;
  logic               done_rwn;
  logic               done_err;
  logic               cfg_valid;
  logic [4:0]         cfg_addr;
  logic [31:0]        cfg_data;
  logic               cfg_rwn;
  logic               cfg_ready;
  logic               eot;
  logic               busy;
  logic               busy_rwn;
  logic [TOW-1:0]     timeout;

  // Per-requester fields, packed onto the flattened buses below.
  logic [L2W-1:0]     f_l2   [NB];
  logic [EXW-1:0]     f_ext  [NB];
  logic [SZW-1:0]     f_size [NB];
  logic               f_rwn  [NB];

  int total = 0;
  int bad   = 0;
  int model_last;

  always #5 clk = ~clk;

  always_comb begin
    req_l2addr  = '0;
    req_extaddr = '0;
    req_size    = '0;
    req_rwn     = '0;
    for (int k = 0; k < NB; k++) begin
      req_l2addr[k*L2W +: L2W]  = f_l2[k];
      req_extaddr[k*EXW +: EXW] = f_ext[k];
      req_size[k*SZW +: SZW]    = f_size[k];
      req_rwn[k]                = f_rwn[k];
    end
  end

  hyper_txn_sched dut (
    .sys_clk_i     (clk),
    .rstn_i        (rstn),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_rwn_i     (req_rwn),
    .req_l2addr_i  (req_l2addr),
    .req_extaddr_i (req_extaddr),
    .req_size_i    (req_size),
    .done_o        (done_o),
    .done_rwn_o    (done_rwn),
    .done_err_o    (done_err),
    .cfg_valid_o   (cfg_valid),
    .cfg_addr_o    (cfg_addr),
    .cfg_data_o    (cfg_data),
    .cfg_rwn_o     (cfg_rwn),
    .cfg_ready_i   (cfg_ready),
    .eot_i         (eot),
    .busy_o        (busy),
    .busy_rwn_o    (busy_rwn),
    .timeout_i     (timeout)
  );

  function automatic logic [63:0] all_outs();
    return 64'({req_ready, done_o, done_rwn, done_err, cfg_valid, cfg_addr,
                cfg_data, cfg_rwn, busy, busy_rwn});
  endfunction

  task automatic rand_fields(input int k, input bit allow_zero);
    f_l2[k]   = L2W'($urandom);
    f_ext[k]  = EXW'($urandom);
    f_rwn[k]  = 1'($urandom);
    f_size[k] = SZW'($urandom_range(1, 1 << 19));
    if (allow_zero && $urandom_range(0, 3) == 0) f_size[k] = '0;
  endtask

  // Serve one transaction from the current request mask and check it end to end.
  task automatic serve_one(input int stall, input int eot_wait, input bit drop,
                           input bit use_to, input bit eot_at_exp, output int lat);
    int            w;
    int            n;
    logic [NB-1:0] oh;
    logic [31:0]   exp_d [4];
    logic          r;
    bit            zero;
    w   = -1;
    lat = 0;
    for (int i = 1; i <= NB; i++) begin
      int c;
      c = (model_last + i) % NB;
      if (w < 0 && req_valid[IW'(c)]) w = c;
    end
    if (w < 0) begin
      total++; bad++;
      $display("FAIL serve_setup: empty request mask %b", req_valid);
      return;
    end
    do begin
      @(negedge clk);
      lat++;
    end while (req_ready === '0 && lat < 8);
    oh = '0;
    oh[IW'(w)] = 1'b1;
    total++;
    if (req_ready !== oh) begin
      bad++;
      $display("FAIL grant: req_ready=%b expected=%b after %0d cycles", req_ready, oh, lat);
    end
    model_last = w;
    r        = f_rwn[IW'(w)];
    zero     = (f_size[IW'(w)] == '0);
    exp_d[0] = 32'(f_l2[IW'(w)]);
    exp_d[1] = 32'(f_size[IW'(w)]);
    exp_d[2] = 32'(f_ext[IW'(w)]);
    exp_d[3] = r ? 32'h3 : 32'h2;
    total++;
    if (cfg_valid !== 1'b0 || done_o !== '0) begin
      bad++;
      $display("FAIL grant_quiet: cfg_valid=%b done=%b expected 0", cfg_valid, done_o);
    end
    if (drop) req_valid[IW'(w)] = 1'b0;
    @(negedge clk);

    if (zero) begin
      total++;
      if ({done_o, done_rwn, done_err, cfg_valid} !== {oh, r, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL zero_done: done=%b rwn=%b err=%b cfg_valid=%b expected done=%b rwn=%b err=0 cfg_valid=0",
                 done_o, done_rwn, done_err, cfg_valid, oh, r);
      end
      @(negedge clk);
      total++;
      if ({done_o, cfg_valid} !== '0) begin
        bad++;
        $display("FAIL zero_after: done=%b cfg_valid=%b expected 0", done_o, cfg_valid);
      end
      return;
    end

    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s <= stall; s++) begin
        total++;
        if ({cfg_valid, cfg_addr, cfg_data, cfg_rwn, done_o} !== {1'b1, 5'(k), exp_d[k], 1'b0, {NB{1'b0}}}) begin
          bad++;
          $display("FAIL cfg_write[%0d] hold %0d: valid=%b addr=%0d data=%h rwn=%b expected valid=1 addr=%0d data=%h rwn=0",
                   k, s, cfg_valid, cfg_addr, cfg_data, cfg_rwn, k, exp_d[k]);
        end
        cfg_ready = (s == stall);
        @(negedge clk);
      end
    end
    cfg_ready = 1'b0;

    if (use_to) begin
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        if (eot_at_exp && n == int'(timeout) - 1) eot = 1'b1;
        @(negedge clk);
        eot = 1'b0;
        n++;
      end
      total++;
      if (n != int'(timeout)) begin
        bad++;
        $display("FAIL busy_cycles: got %0d expected %0d", n, timeout);
      end
      if (!eot_at_exp) begin
        total++;
        if ({cfg_valid, cfg_addr, cfg_data, done_o} !== {1'b1, 5'd3, 32'h4, {NB{1'b0}}}) begin
          bad++;
          $display("FAIL abort_write: valid=%b addr=%0d data=%h done=%b expected 1/3/00000004/0",
                   cfg_valid, cfg_addr, cfg_data, done_o);
        end
        eot = 1'b1;
        cfg_ready = 1'b1;
        @(negedge clk);
        eot = 1'b0;
        cfg_ready = 1'b0;
      end
      total++;
      if ({done_o, done_rwn, done_err, cfg_valid, busy} !== {oh, r, !eot_at_exp, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL timeout_done: done=%b rwn=%b err=%b cfg_valid=%b busy=%b expected done=%b rwn=%b err=%b",
                 done_o, done_rwn, done_err, cfg_valid, busy, oh, r, !eot_at_exp);
      end
    end else begin
      for (int i = 0; i <= eot_wait; i++) begin
        total++;
        if ({busy, busy_rwn, done_o, cfg_valid} !== {1'b1, r, {NB{1'b0}}, 1'b0}) begin
          bad++;
          $display("FAIL busy[%0d]: busy=%b busy_rwn=%b done=%b cfg_valid=%b expected busy=1 busy_rwn=%b",
                   i, busy, busy_rwn, done_o, cfg_valid, r);
        end
        eot = (i == eot_wait);
        @(negedge clk);
      end
      eot = 1'b0;
      total++;
      if ({done_o, done_rwn, done_err, busy} !== {oh, r, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL eot_done: done=%b rwn=%b err=%b busy=%b expected done=%b rwn=%b err=0 busy=0",
                 done_o, done_rwn, done_err, busy, oh, r);
      end
    end
    @(negedge clk);
    total++;
    if ({done_o, busy} !== '0) begin
      bad++;
      $display("FAIL done_pulse: done=%b busy=%b one cycle after completion, expected 0", done_o, busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (all_outs() !== 64'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    rstn = 1'b1;
    model_last = NB - 1;
    @(negedge clk);
    total++;
    if (all_outs() !== 64'd0) begin
      bad++;
      $display("FAIL idle_after_reset: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_contention();
    int lat;
    for (int k = 0; k < NB; k++) rand_fields(k, 1'b0);
    req_valid = '1;
    for (int t = 0; t < 4; t++) begin
      serve_one($urandom_range(0, 1), $urandom_range(0, 3), 1'b0, 1'b0, 1'b0, lat);
    end
    req_valid = '0;
  endtask

  task automatic test_single_write();
    int lat;
    f_l2[0] = 19'h100; f_size[0] = 20'd64; f_ext[0] = 32'h2000; f_rwn[0] = 1'b0;
    req_valid = 2'b01;
    serve_one(0, 2, 1'b1, 1'b0, 1'b0, lat);
    total++;
    if (lat != 1) begin
      bad++;
      $display("FAIL grant_latency: got %0d cycles expected 1", lat);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    for (int t = 0; t < 2; t++) begin
      rand_fields(t, 1'b0);
      req_valid = '0;
      req_valid[IW'(t)] = 1'b1;
      serve_one(3, 1, 1'b1, 1'b0, 1'b0, lat);
    end
  endtask

  task automatic test_zero_size();
    int lat;
    rand_fields(1, 1'b0);
    f_size[1] = '0;
    req_valid = 2'b10;
    serve_one(0, 0, 1'b1, 1'b0, 1'b0, lat);
  endtask

  task automatic test_eot_idle();
    req_valid = '0;
    eot = 1'b1;
    @(negedge clk);
    eot = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({req_ready, done_o, busy, cfg_valid} !== '0) begin
        bad++;
        $display("FAIL eot_idle[%0d]: ready=%b done=%b busy=%b cfg_valid=%b expected 0",
                 i, req_ready, done_o, busy, cfg_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int lat;
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < NB; k++) rand_fields(k, 1'b1);
      req_valid = req_valid | NB'($urandom);
      if (req_valid == '0) req_valid[IW'($urandom_range(0, NB - 1))] = 1'b1;
      serve_one($urandom_range(0, 2), $urandom_range(0, 4), 1'b1, 1'b0, 1'b0, lat);
    end
    req_valid = '0;
  endtask

`ifdef HYPER_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    timeout = 16'd8;
    for (int t = 0; t < 2; t++) begin
      rand_fields(0, 1'b0);
      req_valid = 2'b01;
      serve_one(0, 0, 1'b1, 1'b1, t == 1, lat);
    end
    timeout = '0;
  endtask
`endif

  task automatic test_reset_wext();
    int n;
    int lat;
    rand_fields(0, 1'b0);
    rand_fields(1, 1'b0);
    req_valid = 2'b01;
    cfg_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (req_ready !== '0) req_valid = '0;
    end while (!(cfg_valid === 1'b1 && cfg_addr === 5'd2) && n < 20);
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL reach_w_ext: config index 2 not seen within %0d cycles", n);
    end
    rstn = 1'b0;
    cfg_ready = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    total++;
    if (all_outs() !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid_txn: got %h expected 0", all_outs());
    end
    rstn = 1'b1;
    model_last = NB - 1;
    serve_one(0, 1, 1'b1, 1'b0, 1'b0, lat);
    req_valid = '0;
    total++;
    if (lat != 1) begin
      bad++;
      $display("FAIL post_reset_latency: got %0d cycles expected 1", lat);
    end
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    cfg_ready = 1'b0;
    eot       = 1'b0;
    timeout   = '0;
    for (int k = 0; k < NB; k++) begin
      f_l2[k] = '0; f_ext[k] = '0; f_size[k] = '0; f_rwn[k] = 1'b0;
    end
    model_last = NB - 1;

    test_reset();
    test_contention();
    test_single_write();
    test_backpressure();
    test_zero_size();
    test_eot_idle();
    test_random();
`ifdef HYPER_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_wext();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
